baud_tick_gen: RTL and testbench
================================

Name: baud_tick_gen

Overview:
- Parametrised successor to the fixed divide-by-16 UART clock generator.
- Fractional-N prescaler produces the oversample tick; an oversample phase counter derives the bit tick, the mid-bit sample tick and a legacy square-wave clock.
- Runtime-loadable divisor, enable, and phase restart so RX can realign on a start-bit edge.
- Sits between the system clock and the UART TX/RX engines; one instance per UART channel.

Parameters:
- ICLK, 50_000_000, input clock frequency in Hz.
- BAUD, 9600, reset-time baud rate.
- OVERSAMPLE, 16, oversample ticks per bit; power of 2, at least 4.
- DIV_W, 16, integer divisor width.
- FRAC_W, 8, fractional divisor/accumulator width.

Ports:
- i_clk  in  1  system clock.
- i_nrst  in  1  asynchronous, active-low reset.
- i_en  in  1  count enable; low freezes all counters.
- i_restart  in  1  synchronous phase realign, one-cycle pulse.
- i_div_we  in  1  divisor load strobe.
- i_div_int  in  DIV_W  integer part of clocks per oversample tick.
- i_div_frac  in  FRAC_W  fractional part, in units of 1/2^FRAC_W.
- o_os_tick  out  1  one-cycle oversample pulse.
- o_mid_tick  out  1  one-cycle mid-bit sample pulse.
- o_bit_tick  out  1  one-cycle bit-boundary pulse.
- o_os_cnt  out  log2(OVERSAMPLE)  current oversample phase.
- o_clk  out  1  legacy baud square wave (MSB of o_os_cnt).
- o_div_busy  out  1  a divisor load is pending.

Behaviour:
- Reset (async, i_nrst=0):
  - pcnt, acc, oscnt and pending flag clear to 0.
  - Active and pending divisor load DIV_INT_RST and DIV_FRAC_RST from the package.
  - All outputs 0.
- Default divisor at ICLK=50e6, BAUD=9600, OS=16: DIV_INT_RST = floor(ICLK/(BAUD*OS)) = 325; DIV_FRAC_RST = floor(ICLK*2^FRAC_W/(BAUD*OS)) mod 2^FRAC_W = 133.
- Prescaler:
  - Each period k, compute {c,sum} = acc + div_frac (FRAC_W+1 bits). Period length = div_int + c.
  - pcnt counts 0 .. length-1. At the terminal count: acc <= sum, pcnt <= 0, o_os_tick asserts for exactly the next cycle (registered).
  - div_int = 0 is clamped to 1. div_int=1 with frac=0 gives o_os_tick every cycle.
- First tick timing: o_os_tick is high in the cycle after the length-th enabled clock following restart or reset release.
- Phase counter (oscnt, 0..OS-1): increments on each os tick and wraps to 0.
  - o_mid_tick coincides with the os tick taken while oscnt==OS/2-1.
  - o_bit_tick coincides with the os tick taken while oscnt==OS-1.
  - o_os_cnt shows oscnt and is registered, so it updates in the same cycle as the tick pulse.
- Divisor load:
  - i_div_we captures i_div_int/i_div_frac into pending and sets o_div_busy.
  - The pending value becomes active at the next terminal count (the period just ending uses the old value), or on i_restart, or on the next cycle if i_en=0.
  - o_div_busy clears when the value is applied.
  - A second write while busy overwrites pending (last write wins).
- i_en=0: pcnt, acc and oscnt hold; no tick pulses. Re-enabling resumes mid-period with no extra or lost tick.
- i_restart:
  - Clears pcnt, acc and oscnt; applies pending divisor.
  - No tick is emitted in the restart cycle, even if a terminal count coincides.
  - Works regardless of i_en.
- Priority: reset > restart > en=0 > divisor apply at terminal > count.
- Reset mid-operation: immediate async clear, including any in-flight tick pulse.
- Widths: pcnt is DIV_W bits; length uses DIV_W+1 bits to avoid overflow when div_int is all-ones and c=1.

Decomposition:
- Package baud_pkg:
  - clog2 function.
  - DIV_INT_RST and DIV_FRAC_RST computed from ICLK/BAUD/OVERSAMPLE/FRAC_W.
  - OS_W = clog2(OVERSAMPLE).
- Sub-module frac_prescaler:
  - Owns pcnt, acc, active/pending divisor and the clamp.
  - Outputs the raw terminal strobe and div_busy.
- Top: oscnt, tick decode/registration, o_clk, restart/enable gating.

Test Plan:
- Reset, then run with defaults (div_int=325, frac=133): 2^FRAC_W=256 os ticks span exactly 325*256+133 = 83333 clocks; o_bit_tick every 16 os ticks; o_clk toggles every 8 os ticks.
- Load div_int=3, frac=0, then i_restart: o_os_tick every 3 clocks; o_mid_tick at clock 24; o_bit_tick at clock 48 after restart; o_div_busy high for exactly the cycles until restart.
- Load div_int=2, frac=128 (FRAC_W=8): periods alternate 2,3 starting with 2; 16 os ticks in 40 clocks; acc returns to 0 after each pair.
- i_en low for 10 clocks mid-period (pcnt=1 of 3): no ticks while low; next os tick exactly 2 enabled clocks after re-enable.
- i_restart in the same cycle as a terminal count with oscnt=15: no o_os_tick/o_bit_tick; oscnt=0; next bit tick 16 os ticks later.
- Write div_int=0: behaves as 1, with o_os_tick every cycle. Assert i_nrst low mid-pulse: all outputs 0 within the same cycle; divisor returns to 325/133.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared constants and helpers for the UART baud tick generator.
// Reset divisor is derived from clock/baud/oversample so each channel boots at its nominal rate.
package baud_pkg;

  localparam int unsigned ICLK_DEF       = 50_000_000;
  localparam int unsigned BAUD_DEF       = 9600;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DIV_W_DEF      = 16;
  localparam int unsigned FRAC_W_DEF     = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  // Clocks per oversample tick, scaled by 2^frac_w (integer and fraction packed together).
  function automatic longint unsigned div_scaled(input int unsigned iclk, input int unsigned baud,
                                                 input int unsigned os, input int unsigned frac_w);
    return (64'(iclk) << frac_w) / (64'(baud) * 64'(os));
  endfunction

  function automatic int unsigned div_int_rst(input int unsigned iclk, input int unsigned baud,
                                              input int unsigned os, input int unsigned frac_w);
    return 32'(div_scaled(iclk, baud, os, frac_w) >> frac_w);
  endfunction

  function automatic int unsigned div_frac_rst(input int unsigned iclk, input int unsigned baud,
                                               input int unsigned os, input int unsigned frac_w);
    return 32'(div_scaled(iclk, baud, os, frac_w) & ((64'(1) << frac_w) - 64'(1)));
  endfunction

  localparam int unsigned DIV_INT_RST  = div_int_rst(ICLK_DEF, BAUD_DEF, OVERSAMPLE_DEF, FRAC_W_DEF);
  localparam int unsigned DIV_FRAC_RST = div_frac_rst(ICLK_DEF, BAUD_DEF, OVERSAMPLE_DEF, FRAC_W_DEF);
  localparam int unsigned OS_W         = clog2(OVERSAMPLE_DEF);

endpackage

// File: rtl/baud_tick_gen_frac_prescaler.sv
// Fractional-N prescaler: period alternates div_int / div_int+1 driven by a fraction accumulator.
// Holds the active and pending divisor; pending is applied only on a period boundary, restart or idle.
module baud_tick_gen_frac_prescaler
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W        = DIV_W_DEF,
  parameter int unsigned FRAC_W       = FRAC_W_DEF,
  parameter int unsigned DIV_INT_INIT = DIV_INT_RST,
  parameter int unsigned DIV_FRAC_INIT = DIV_FRAC_RST
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_en,
  input  logic              i_restart,
  input  logic              i_div_we,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  output logic              o_term_c,
  output logic              o_div_busy
);

  logic [DIV_W-1:0]  r_pcnt;
  logic [FRAC_W-1:0] r_acc;
  logic [DIV_W-1:0]  r_div_int;
  logic [FRAC_W-1:0] r_div_frac;
  logic [DIV_W-1:0]  r_pend_int;
  logic [FRAC_W-1:0] r_pend_frac;
  logic              r_busy;

  logic [DIV_W-1:0]  w_div_int_eff;
  logic [FRAC_W:0]   w_sum;
  logic [DIV_W:0]    w_len;
  logic              w_term;
  logic              w_apply;

  // Zero divisor would never terminate; treat it as divide-by-one.
  assign w_div_int_eff = (r_div_int == '0) ? DIV_W'(1) : r_div_int;
  assign w_sum         = {1'b0, r_acc} + {1'b0, r_div_frac};
  assign w_len         = {1'b0, w_div_int_eff} + (DIV_W+1)'(w_sum[FRAC_W]);
  assign w_term        = ({1'b0, r_pcnt} == (w_len - (DIV_W+1)'(1)));
  assign w_apply       = r_busy & (i_restart | ~i_en | w_term);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_pcnt      <= '0;
      r_acc       <= '0;
      r_div_int   <= DIV_W'(DIV_INT_INIT);
      r_div_frac  <= FRAC_W'(DIV_FRAC_INIT);
      r_pend_int  <= DIV_W'(DIV_INT_INIT);
      r_pend_frac <= FRAC_W'(DIV_FRAC_INIT);
      r_busy      <= 1'b0;
    end else begin
      if (i_restart) begin
        r_pcnt <= '0;
        r_acc  <= '0;
      end else if (i_en) begin
        if (w_term) begin
          r_pcnt <= '0;
          r_acc  <= w_sum[FRAC_W-1:0];
        end else begin
          r_pcnt <= r_pcnt + DIV_W'(1);
        end
      end
      if (w_apply) begin
        r_div_int  <= r_pend_int;
        r_div_frac <= r_pend_frac;
        r_busy     <= 1'b0;
      end
      // A write in the same cycle as an apply stays pending for the next boundary.
      if (i_div_we) begin
        r_pend_int  <= i_div_int;
        r_pend_frac <= i_div_frac;
        r_busy      <= 1'b1;
      end
    end
  end

  assign o_term_c   = w_term & i_en;
  assign o_div_busy = r_busy;

endmodule

// File: rtl/baud_tick_gen.sv
// UART baud tick generator: oversample tick from a fractional prescaler, plus phase counter
// that derives mid-bit sample tick, bit-boundary tick and the legacy square-wave clock.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned ICLK       = ICLK_DEF,
  parameter int unsigned BAUD       = BAUD_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned FRAC_W     = FRAC_W_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_nrst,
  input  logic                           i_en,
  input  logic                           i_restart,
  input  logic                           i_div_we,
  input  logic [DIV_W-1:0]               i_div_int,
  input  logic [FRAC_W-1:0]              i_div_frac,
  output logic                           o_os_tick,
  output logic                           o_mid_tick,
  output logic                           o_bit_tick,
  output logic [clog2(OVERSAMPLE)-1:0]   o_os_cnt,
  output logic                           o_clk,
  output logic                           o_div_busy
);

  localparam int unsigned CNT_W     = clog2(OVERSAMPLE);
  localparam int unsigned INT_INIT  = div_int_rst(ICLK, BAUD, OVERSAMPLE, FRAC_W);
  localparam int unsigned FRAC_INIT = div_frac_rst(ICLK, BAUD, OVERSAMPLE, FRAC_W);

  logic             w_term;
  logic             w_tick;
  logic [CNT_W-1:0] r_oscnt;
  logic             r_os_tick;
  logic             r_mid_tick;
  logic             r_bit_tick;

  baud_tick_gen_frac_prescaler #(
    .DIV_W        (DIV_W),
    .FRAC_W       (FRAC_W),
    .DIV_INT_INIT (INT_INIT),
    .DIV_FRAC_INIT(FRAC_INIT)
  ) u_presc (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_en       (i_en),
    .i_restart  (i_restart),
    .i_div_we   (i_div_we),
    .i_div_int  (i_div_int),
    .i_div_frac (i_div_frac),
    .o_term_c   (w_term),
    .o_div_busy (o_div_busy)
  );

  // Restart suppresses a coinciding terminal count so RX realigns cleanly.
  assign w_tick = w_term & ~i_restart;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_oscnt    <= '0;
      r_os_tick  <= 1'b0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
    end else begin
      r_os_tick  <= w_tick;
      r_mid_tick <= w_tick & (r_oscnt == CNT_W'(OVERSAMPLE/2 - 1));
      r_bit_tick <= w_tick & (r_oscnt == CNT_W'(OVERSAMPLE - 1));
      if (i_restart) begin
        r_oscnt <= '0;
      end else if (w_tick) begin
        r_oscnt <= r_oscnt + CNT_W'(1);
      end
    end
  end

  assign o_os_tick  = r_os_tick;
  assign o_mid_tick = r_mid_tick;
  assign o_bit_tick = r_bit_tick;
  assign o_os_cnt   = r_oscnt;
  assign o_clk      = r_oscnt[CNT_W-1];

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: per-cycle vector table plus timing sequences.
module tb_baud_tick_gen;
  import baud_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_en;
  logic        i_restart;
  logic        i_div_we;
  logic [15:0] i_div_int;
  logic [7:0]  i_div_frac;
  logic        o_os_tick, o_mid_tick, o_bit_tick, o_clk, o_div_busy;
  logic [3:0]  o_os_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        en, rs, we;
    logic [15:0] di;
    logic [7:0]  df;
    logic        os, busy;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[26];

  baud_tick_gen dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_en(i_en), .i_restart(i_restart),
    .i_div_we(i_div_we), .i_div_int(i_div_int), .i_div_frac(i_div_frac),
    .o_os_tick(o_os_tick), .o_mid_tick(o_mid_tick), .o_bit_tick(o_bit_tick),
    .o_os_cnt(o_os_cnt), .o_clk(o_clk), .o_div_busy(o_div_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t v(input logic en, input logic rs, input logic we, input logic [15:0] di,
                             input logic [7:0] df, input logic os, input logic busy, input logic [3:0] cnt);
    vec_t r;
    r.en = en; r.rs = rs; r.we = we; r.di = di; r.df = df; r.os = os; r.busy = busy; r.cnt = cnt;
    return r;
  endfunction

  // Step until n os ticks are seen or the budget runs out; edges counted from the call.
  task automatic run_ticks(input int n, input int budget, input int per,
                           output int edges, output int nbit, output int nmid, output int ntog,
                           output int fmid, output int fbit, output int bad);
    int   ticks;
    logic prev_clk;
    edges = 0; ticks = 0; nbit = 0; nmid = 0; ntog = 0; fmid = 0; fbit = 0; bad = 0;
    prev_clk = o_clk;
    while (ticks < n && edges < budget) begin
      step();
      edges++;
      if (o_os_tick) begin
        ticks++;
        if (per != 0 && (edges % per) != 0) bad++;
      end
      if (o_mid_tick) begin nmid++; if (fmid == 0) fmid = edges; end
      if (o_bit_tick) begin nbit++; if (fbit == 0) fbit = edges; end
      if (o_clk != prev_clk) ntog++;
      prev_clk = o_clk;
    end
  endtask

  task automatic load_restart(input logic [15:0] di, input logic [7:0] df);
    i_div_we = 1'b1; i_div_int = di; i_div_frac = df;
    step();
    i_div_we = 1'b0; i_restart = 1'b1;
    step();
    i_restart = 1'b0;
  endtask

  initial begin
    int e, e1, e2, nb, nm, nt, fm, fb, bad, tot_b, tot_m, tot_t, cnt;

    i_nrst = 1'b0; i_en = 1'b1; i_restart = 1'b0; i_div_we = 1'b0;
    i_div_int = '0; i_div_frac = '0;
    step(); step();
    check("rst_os_tick",  int'(o_os_tick), 0);
    check("rst_mid_tick", int'(o_mid_tick), 0);
    check("rst_bit_tick", int'(o_bit_tick), 0);
    check("rst_os_cnt",   int'(o_os_cnt), 0);
    check("rst_o_clk",    int'(o_clk), 0);
    check("rst_busy",     int'(o_div_busy), 0);

    // Default divisor 325 + 133/256
    i_nrst = 1'b1;
    run_ticks(1, 400, 0, e1, nb, nm, nt, fm, fb, bad);
    check("dflt_first_tick_edge", e1, 325);
    check("dflt_cnt_after_1", int'(o_os_cnt), 1);
    tot_t = nt;
    run_ticks(15, 6000, 0, e2, nb, nm, nt, fm, fb, bad);
    check("dflt_16_ticks_edge", e1 + e2, 5208);
    check("dflt_bits_16", nb, 1);
    check("dflt_mids_16", nm, 1);
    tot_b = nb; tot_m = nm; tot_t += nt;
    run_ticks(112, 40000, 0, e, nb, nm, nt, fm, fb, bad);
    check("dflt_128_ticks_edge", e1 + e2 + e, 41666);
    check("dflt_bits_128", tot_b + nb, 8);
    check("dflt_mids_128", tot_m + nm, 8);
    check("dflt_clk_toggles", tot_t + nt, 16);
    check("dflt_cnt_wrap", int'(o_os_cnt), 0);

    // Per-cycle table: load 3/0 + restart, enable freeze, restart on terminal, idle apply, 2/128
    tbl[0]  = v(1'b1, 1'b0, 1'b1, 16'd3, 8'd0,   1'b0, 1'b1, 4'd0);
    tbl[1]  = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b0, 1'b1, 4'd0);
    tbl[2]  = v(1'b1, 1'b1, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd0);
    tbl[3]  = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd0);
    tbl[4]  = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd0);
    tbl[5]  = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b1, 1'b0, 4'd1);
    tbl[6]  = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd1);
    tbl[7]  = v(1'b0, 1'b0, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd1);
    tbl[8]  = v(1'b0, 1'b0, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd1);
    tbl[9]  = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd1);
    tbl[10] = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b1, 1'b0, 4'd2);
    tbl[11] = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd2);
    tbl[12] = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd2);
    tbl[13] = v(1'b1, 1'b1, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd0);
    tbl[14] = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd0);
    tbl[15] = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b0, 1'b0, 4'd0);
    tbl[16] = v(1'b1, 1'b0, 1'b0, 16'd3, 8'd0,   1'b1, 1'b0, 4'd1);
    tbl[17] = v(1'b0, 1'b0, 1'b1, 16'd2, 8'd128, 1'b0, 1'b1, 4'd1);
    tbl[18] = v(1'b0, 1'b0, 1'b0, 16'd2, 8'd128, 1'b0, 1'b0, 4'd1);
    tbl[19] = v(1'b1, 1'b0, 1'b0, 16'd2, 8'd128, 1'b0, 1'b0, 4'd1);
    tbl[20] = v(1'b1, 1'b0, 1'b0, 16'd2, 8'd128, 1'b1, 1'b0, 4'd2);
    tbl[21] = v(1'b1, 1'b0, 1'b0, 16'd2, 8'd128, 1'b0, 1'b0, 4'd2);
    tbl[22] = v(1'b1, 1'b0, 1'b0, 16'd2, 8'd128, 1'b0, 1'b0, 4'd2);
    tbl[23] = v(1'b1, 1'b0, 1'b0, 16'd2, 8'd128, 1'b1, 1'b0, 4'd3);
    tbl[24] = v(1'b1, 1'b0, 1'b0, 16'd2, 8'd128, 1'b0, 1'b0, 4'd3);
    tbl[25] = v(1'b1, 1'b0, 1'b0, 16'd2, 8'd128, 1'b1, 1'b0, 4'd4);
    for (int i = 0; i < 26; i++) begin
      logic [7:0] act, exp;
      i_en = tbl[i].en; i_restart = tbl[i].rs; i_div_we = tbl[i].we;
      i_div_int = tbl[i].di; i_div_frac = tbl[i].df;
      step();
      act = {o_os_tick, o_mid_tick, o_bit_tick, o_os_cnt, o_div_busy};
      exp = {tbl[i].os, 1'b0, 1'b0, tbl[i].cnt, tbl[i].busy};
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL vec[%0d] {os,mid,bit,cnt,busy}: got %b expected %b", i, act, exp);
    end
    i_en = 1'b1; i_restart = 1'b0; i_div_we = 1'b0;

    // 2 + 1/2: periods 2,3,2,3... so 16 ticks in 40 clocks
    i_restart = 1'b1; step(); i_restart = 1'b0;
    run_ticks(16, 100, 0, e, nb, nm, nt, fm, fb, bad);
    check("frac_16_ticks_edge", e, 40);
    check("frac_mid_edge", fm, 20);
    check("frac_bit_edge", fb, 40);

    // Integer divisor 3: tick every 3rd clock, mid at 24, bit at 48
    load_restart(16'd3, 8'd0);
    check("div3_busy_after_restart", int'(o_div_busy), 0);
    run_ticks(16, 100, 3, e, nb, nm, nt, fm, fb, bad);
    check("div3_16_ticks_edge", e, 48);
    check("div3_misaligned_ticks", bad, 0);
    check("div3_mid_edge", fm, 24);
    check("div3_bit_edge", fb, 48);

    // Freeze at pcnt=1 for 10 clocks
    step();
    i_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); if (o_os_tick) cnt++; end
    check("en_low_ticks", cnt, 0);
    i_en = 1'b1;
    step();
    check("en_resume_edge1", int'(o_os_tick), 0);
    step();
    check("en_resume_edge2", int'(o_os_tick), 1);

    // Restart coinciding with terminal count while oscnt=15
    i_restart = 1'b1; step(); i_restart = 1'b0;
    run_ticks(15, 100, 0, e, nb, nm, nt, fm, fb, bad);
    check("rt_cnt15", int'(o_os_cnt), 15);
    step(); step();
    i_restart = 1'b1; step(); i_restart = 1'b0;
    check("rt_no_os_tick", int'(o_os_tick), 0);
    check("rt_no_bit_tick", int'(o_bit_tick), 0);
    check("rt_cnt_cleared", int'(o_os_cnt), 0);
    run_ticks(16, 100, 0, e, nb, nm, nt, fm, fb, bad);
    check("rt_next_bit_edge", fb, 48);

    // div_int=0 clamps to 1: tick every cycle, then async reset mid-pulse
    load_restart(16'd0, 8'd0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin step(); if (o_os_tick) cnt++; end
    check("div0_ticks_in_5", cnt, 5);
    check("div0_cnt", int'(o_os_cnt), 5);
    #1;
    i_nrst = 1'b0;
    #1;
    check("arst_os_tick", int'(o_os_tick), 0);
    check("arst_os_cnt", int'(o_os_cnt), 0);
    check("arst_o_clk_busy", int'({o_clk, o_div_busy, o_mid_tick, o_bit_tick}), 0);
    #2;
    i_nrst = 1'b1;
    run_ticks(1, 400, 0, e, nb, nm, nt, fm, fb, bad);
    check("arst_divisor_restored", e, 325);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
